// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped branch target buffer with 2-bit saturating
// counters. Lookup for the fetch PC is combinational; training happens at the
// clock edge from the branch resolved in MEM, which also produces the
// combinational mispredict/redirect request for the front of the pipe.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int IDXW    = $clog2(ENTRIES)
) (
    input  logic        CLK,
    input  logic        nRST,
    // fetch-side lookup
    input  logic [31:0] imemaddr_if,
    output logic        branch_hit_if,
    output logic [31:0] target_address_if,
    output logic [1:0]  branch_history_if,
    // resolved-branch update from MEM
    input  logic        update_en,
    input  logic [31:0] update_pc,
    input  logic        update_taken,
    input  logic [31:0] update_target,
    input  logic        update_hit,
    input  logic [31:0] update_pred_target,
    input  logic [31:0] update_pc_next,
    output logic        mispredict,
    output logic [31:0] correct_pc
);

    localparam int TAGW = 32 - IDXW - 2;

    // Table storage; ctr encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T
    logic [ENTRIES-1:0] valid_q;
    logic [TAGW-1:0]    tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    logic [IDXW-1:0] lk_idx;
    logic [TAGW-1:0] lk_tag;
    logic            lk_match;
    logic [IDXW-1:0] up_idx;
    logic [TAGW-1:0] up_tag;
    logic            up_match;

    // Byte-offset bits of word-aligned PCs carry no information here.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{imemaddr_if[1:0], update_pc[1:0]};

    assign lk_idx = imemaddr_if[IDXW+1:2];
    assign lk_tag = imemaddr_if[31:IDXW+2];
    assign up_idx = update_pc[IDXW+1:2];
    assign up_tag = update_pc[31:IDXW+2];

    // Fetch lookup: reads current table contents, no bypass from a same-cycle update
    always_comb begin
        lk_match          = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        branch_hit_if     = 1'b0;
        target_address_if = 32'd0;
        branch_history_if = 2'b00;
        if (lk_match) begin
            branch_hit_if     = ctr_q[lk_idx][1];
            target_address_if = target_q[lk_idx];
            branch_history_if = ctr_q[lk_idx];
        end
    end

    // Resolution check: wrong direction, or taken to a different target than predicted
    always_comb begin
        mispredict = 1'b0;
        correct_pc = 32'd0;
        if (update_en) begin
            mispredict = (update_hit != update_taken) ||
                         (update_hit && update_taken && (update_pred_target != update_target));
        end
        if (mispredict) begin
            correct_pc = update_taken ? update_target : update_pc_next;
        end
    end

    assign up_match = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    // Training: saturating counter on a hit, allocate on a taken miss, ignore a not-taken miss
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= 32'd0;
                ctr_q[i]    <= 2'b00;
            end
        end else if (update_en) begin
            if (up_match) begin
                if (update_taken) begin
                    if (ctr_q[up_idx] != 2'b11) begin
                        ctr_q[up_idx] <= ctr_q[up_idx] + 2'd1;
                    end
                    target_q[up_idx] <= update_target;
                end else if (ctr_q[up_idx] != 2'b00) begin
                    ctr_q[up_idx] <= ctr_q[up_idx] - 2'd1;
                end
            end else if (update_taken) begin
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= update_target;
                ctr_q[up_idx]    <= 2'b10;
            end
        end
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter: ENTRIES, default 16, number of direct-mapped BTB entries; power of 2, range 4..64.
REQ-002 Parameter: IDXW, default log2(ENTRIES), index width.
REQ-003 Clock and reset: CLK input, 1 bit, clock; nRST input, 1 bit, reset, asynchronous, active-low.
REQ-004 Port imemaddr_if: input, 32 bits, fetch PC being looked up.
REQ-005 Port branch_hit_if: output, 1 bit, predict taken for this fetch.
REQ-006 Port target_address_if: output, 32 bits, predicted target.
REQ-007 Port branch_history_if: output, 2 bits, counter value read at lookup; it travels down the pipe.
REQ-008 Port update_en: input, 1 bit, resolved beq/bne is in MEM this cycle.
REQ-009 Port update_pc: input, 32 bits, PC of the resolved branch.
REQ-010 Port update_taken: input, 1 bit, actual outcome.
REQ-011 Port update_target: input, 32 bits, actual taken target.
REQ-012 Port update_hit: input, 1 bit, branch_hit value carried with that branch.
REQ-013 Port update_pred_target: input, 32 bits, target_address value carried with that branch.
REQ-014 Port mispredict: output, 1 bit, flush request for IF/ID, ID/EX and EX/MEM.
REQ-015 Port correct_pc: output, 32 bits, redirect PC when mispredict=1.
REQ-016 Port update_pc_next: input, 32 bits, update_pc+4 (not-taken path).

Function
REQ-020 Each entry holds: valid (1), tag = pc[31:IDXW+2], target (32), ctr (2).
REQ-021 Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-022 Lookup is combinational and uses idx = imemaddr_if[IDXW+1:2].
REQ-023 On lookup, match = valid & tag equal; branch_hit_if = match & ctr[1]; target_address_if = target when match, else 0.
REQ-024 On lookup, branch_history_if = ctr when match, else 00.
REQ-025 Update is registered at the posedge of CLK with update_en=1; the index and tag come from update_pc.
REQ-026 Update, tag match and valid: ctr saturating increments if taken, decrements if not (11 stays 11, 00 stays 00); if taken, target <= update_target.
REQ-027 Update, miss and taken: allocate/replace the entry with valid=1, new tag, target=update_target, ctr=10.
REQ-028 Update, miss and not taken: no state change.
REQ-029 Mispredict is combinational and only asserted with update_en=1, when any of the following holds:
- update_hit != update_taken, or
- update_hit & update_taken & update_pred_target != update_target.
REQ-030 correct_pc = update_target when update_taken, else update_pc_next; it is 0 when mispredict=0.
REQ-031 Simultaneous lookup and update of the same index: the lookup returns pre-update contents; the new value is visible the next cycle (no bypass).
REQ-032 With update_en=0, storage holds its value; there is no stall input, and lookup is repeated each cycle with whatever PC is applied.
REQ-033 Outputs have zero-cycle latency from their inputs; storage has one-cycle write latency.

Reset
REQ-040 While nRST=0, all valid=0, tag=0, target=0, ctr=00, taking effect immediately and asynchronously.
REQ-041 Under reset, outputs follow the empty table: branch_hit_if=0, target_address_if=0, branch_history_if=00, and mispredict=0 unless update_en=1.
REQ-042 Reset asserted mid-update discards the pending write.

Verification
REQ-050 After reset, imemaddr_if=0x40 -> branch_hit_if=0, target_address_if=0, branch_history_if=00.
REQ-051 Allocate, then hit:
- Update pc=0x40, taken, target=0x100, update_hit=0 -> mispredict=1, correct_pc=0x100.
- Next cycle, lookup 0x40 -> hit=1, target=0x100, history=10.
REQ-052 Saturation and the not-taken path:
- Three taken updates to 0x40 -> ctr=11.
- Two not-taken updates -> ctr=01, and lookup hit=0.
- A not-taken update with update_hit=1 -> mispredict=1, correct_pc=update_pc_next=0x44.
REQ-053 Tag alias (ENTRIES=16): 0x40 allocated, then 0x440 taken target 0x200 -> entry replaced; lookup 0x40 -> hit=0, lookup 0x440 -> hit=1, target 0x200.
REQ-054 Same-cycle lookup and update of 0x80 (first allocate) -> that cycle hit=0, next cycle hit=1.
REQ-055 Populate 4 entries, pulse nRST low mid-cycle -> all lookups miss immediately; a wrong-target case (update_hit=1, pred 0x100, actual 0x104) -> mispredict=1.
